// File: rtl/adpll_pkg.sv
// Shared types and default constants for the ADPLL loop filter.
package adpll_pkg;

   // Loop filter sequencing: capture -> integrate -> sum.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INTEG = 2'd1,
      SUM   = 2'd2
   } lf_state_t;

   localparam int DEF_WIDTH      = 5;
   localparam int DEF_ACC_WIDTH  = 16;
   localparam int DEF_OUT_WIDTH  = 12;
   localparam int DEF_KP_SHIFT   = 2;
   localparam int DEF_KI_SHIFT   = 0;
   localparam int DEF_CENTER     = 2048;
   localparam int DEF_LOCK_TOL   = 1;
   localparam int DEF_LOCK_COUNT = 8;

endpackage

// File: rtl/signed_saturate.sv
// Signed clamp of an IN_W-bit value into the OUT_W-bit signed range.
module signed_saturate #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   // Output range limits, sign-extended to the input width for comparison.
   localparam logic signed [IN_W-1:0] MAX_EXT =
      {{(IN_W-OUT_W){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_EXT =
      {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // Clamp at either rail, otherwise pass the low bits through unchanged.
   always_comb begin
      dout = din[OUT_W-1:0];
      if (din > MAX_EXT) begin
         dout = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (din < MIN_EXT) begin
         dout = {1'b1, {(OUT_W-1){1'b0}}};
      end
   end

endmodule

// File: rtl/loop_filter.sv
// Proportional-integral loop filter turning phase-detector error into a DCO
// control word, with overrun detection and a lock indicator.
// Handshake: pd_valid_i is a one-cycle strobe accepted only while idle;
// control_valid_o is a one-cycle strobe qualifying control_word_o.
module loop_filter
   import adpll_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int KP_SHIFT   = DEF_KP_SHIFT,
   parameter int KI_SHIFT   = DEF_KI_SHIFT,
   parameter int CENTER     = DEF_CENTER,
   parameter int LOCK_TOL   = DEF_LOCK_TOL,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic                 fpga_clk_i,
   input  logic                 reset_i,
   input  logic [WIDTH-1:0]     pd_clock_cycles_i,
   input  logic                 pd_valid_i,
   output logic [OUT_WIDTH-1:0] control_word_o,
   output logic                 control_valid_o,
   output logic                 busy_o,
   output logic                 lock_o,
   output logic                 overrun_o
);

   // Integrator update width leaves headroom for the shifted error.
   localparam int INT_W  = ACC_WIDTH + KI_SHIFT + 2;
   // Output sum is ACC_WIDTH+2 bits, widened only when CENTER or the
   // proportional term would not otherwise fit (small accumulators).
   localparam int BASE_A = (ACC_WIDTH > OUT_WIDTH + 1) ? ACC_WIDTH : OUT_WIDTH + 1;
   localparam int BASE_W = (BASE_A > WIDTH + KP_SHIFT + 1) ? BASE_A : WIDTH + KP_SHIFT + 1;
   localparam int SUM_W  = BASE_W + 2;
   localparam int CNT_W  = $clog2(LOCK_COUNT + 1);

   localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER);
   localparam logic signed [WIDTH:0]   TOL_S    = (WIDTH+1)'(LOCK_TOL);
   localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(LOCK_COUNT);

   lf_state_t                  state_q, state_d;
   logic signed [WIDTH-1:0]    e_q;
   logic signed [ACC_WIDTH-1:0] integ_q, integ_sat;
   logic signed [INT_W-1:0]    integ_sum, e_int;
   logic signed [SUM_W-1:0]    word_sum, e_sum, integ_ext;
   logic signed [OUT_WIDTH:0]  word_sat;
   logic [OUT_WIDTH-1:0]       word_clamped;
   logic signed [WIDTH:0]      e_wide, e_mag;
   logic                       in_tol;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   // Next-state sequencing: a sample walks IDLE -> INTEG -> SUM -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pd_valid_i) state_d = INTEG;
         INTEG:   state_d = SUM;
         SUM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: saturating integrator, PI sum, and lock tolerance test.
   always_comb begin
      e_int     = {{(INT_W-WIDTH){e_q[WIDTH-1]}}, e_q};
      integ_sum = {{(INT_W-ACC_WIDTH){integ_q[ACC_WIDTH-1]}}, integ_q} + (e_int <<< KI_SHIFT);

      e_sum     = {{(SUM_W-WIDTH){e_q[WIDTH-1]}}, e_q};
      integ_ext = {{(SUM_W-ACC_WIDTH){integ_q[ACC_WIDTH-1]}}, integ_q};
      word_sum  = CENTER_S + (e_sum <<< KP_SHIFT) + integ_ext;
      // Negative results clamp to zero; the saturator handles the top rail.
      word_clamped = word_sat[OUT_WIDTH] ? '0 : word_sat[OUT_WIDTH-1:0];

      // Magnitude at WIDTH+1 bits so the most negative error cannot overflow.
      e_wide = {e_q[WIDTH-1], e_q};
      e_mag  = e_wide[WIDTH] ? -e_wide : e_wide;
      in_tol = (e_mag <= TOL_S);

      cnt_d = '0;
      if (in_tol) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   signed_saturate #(.IN_W(INT_W), .OUT_W(ACC_WIDTH)) u_sat_integ (
      .din  (integ_sum),
      .dout (integ_sat)
   );

   signed_saturate #(.IN_W(SUM_W), .OUT_W(OUT_WIDTH + 1)) u_sat_word (
      .din  (word_sum),
      .dout (word_sat)
   );

   // State, datapath registers and all outputs; reset aborts any sample.
   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         state_q         <= IDLE;
         e_q             <= '0;
         integ_q         <= '0;
         cnt_q           <= '0;
         control_word_o  <= OUT_WIDTH'(CENTER);
         control_valid_o <= 1'b0;
         busy_o          <= 1'b0;
         lock_o          <= 1'b0;
         overrun_o       <= 1'b0;
      end else begin
         state_q         <= state_d;
         busy_o          <= (state_d != IDLE);
         control_valid_o <= (state_q == SUM);
         if (state_q == IDLE && pd_valid_i) e_q <= pd_clock_cycles_i;
         if (state_q == INTEG) integ_q <= integ_sat;
         if (state_q == SUM) begin
            control_word_o <= word_clamped;
            cnt_q          <= cnt_d;
            lock_o         <= (cnt_d == CNT_MAX);
         end
         if (pd_valid_i && state_q != IDLE) overrun_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_loop_filter.sv
// Directed bench for loop_filter: default instance plus an ACC_WIDTH=8 copy.
module tb_loop_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, pv0, cv0, busy0, lock0, ovr0;
   logic [4:0]  pd0;
   logic [11:0] word0;
   logic        rst8, pv8, cv8, busy8, lock8, ovr8;
   logic [4:0]  pd8;
   logic [11:0] word8;

   loop_filter dut (
      .fpga_clk_i(clk), .reset_i(rst0), .pd_clock_cycles_i(pd0), .pd_valid_i(pv0),
      .control_word_o(word0), .control_valid_o(cv0), .busy_o(busy0),
      .lock_o(lock0), .overrun_o(ovr0)
   );

   loop_filter #(.ACC_WIDTH(8)) dut8 (
      .fpga_clk_i(clk), .reset_i(rst8), .pd_clock_cycles_i(pd8), .pd_valid_i(pv8),
      .control_word_o(word8), .control_valid_o(cv8), .busy_o(busy8),
      .lock_o(lock8), .overrun_o(ovr8)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Scoreboards: {lock, word} expected at each control_valid pulse.
   logic [12:0] exp_q0[$];
   logic [12:0] exp_q8[$];

   // Reference model state, one slot per instance.
   int m_integ[2];
   int m_cnt[2];
   int acc_max[2] = '{32767, 127};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_push(input int sel, input int e);
      int w;
      logic [12:0] ent;
      m_integ[sel] = m_integ[sel] + e;
      if (m_integ[sel] > acc_max[sel]) m_integ[sel] = acc_max[sel];
      if (m_integ[sel] < -acc_max[sel] - 1) m_integ[sel] = -acc_max[sel] - 1;
      w = 2048 + 4 * e + m_integ[sel];
      if (w > 4095) w = 4095;
      if (w < 0) w = 0;
      if (e >= -1 && e <= 1) m_cnt[sel] = (m_cnt[sel] < 8) ? m_cnt[sel] + 1 : 8;
      else m_cnt[sel] = 0;
      ent = {(m_cnt[sel] == 8), 12'(w)};
      if (sel == 0) exp_q0.push_back(ent);
      else exp_q8.push_back(ent);
   endtask

   // Advance one cycle, sample after the edge, and score any output pulse.
   task automatic tick();
      logic [12:0] ent;
      @(posedge clk);
      #1;
      if (cv0 === 1'b1) begin
         if (exp_q0.size() == 0) check("spurious_pulse0", cv0, 0);
         else begin
            ent = exp_q0.pop_front();
            check("word0", word0, ent[11:0]);
            check("lock0", lock0, ent[12]);
         end
      end
      if (cv8 === 1'b1) begin
         if (exp_q8.size() == 0) check("spurious_pulse8", cv8, 0);
         else begin
            ent = exp_q8.pop_front();
            check("word8", word8, ent[11:0]);
            check("lock8", lock8, ent[12]);
         end
      end
   endtask

   task automatic do_reset();
      rst0 = 1'b1; rst8 = 1'b1;
      pv0 = 1'b1; pv8 = 1'b1;           // must be ignored while in reset
      pd0 = 5'd7; pd8 = 5'd7;
      tick();
      check("rst_word", word0, 2048);
      check("rst_valid", cv0, 0);
      check("rst_busy", busy0, 0);
      check("rst_lock", lock0, 0);
      check("rst_ovr", ovr0, 0);
      check("rst_busy8", busy8, 0);
      rst0 = 1'b0; rst8 = 1'b0;
      pv0 = 1'b0; pv8 = 1'b0;
      tick();
      check("rst_busy_after", busy0, 0);
      m_integ = '{0, 0};
      m_cnt = '{0, 0};
   endtask

   // One sample: strobe in cycle 0, expect the pulse in cycle 3.
   task automatic send(input int sel, input int e);
      if (sel == 0) begin pv0 = 1'b1; pd0 = 5'(e); end
      else begin pv8 = 1'b1; pd8 = 5'(e); end
      model_push(sel, e);
      tick();
      pv0 = 1'b0; pv8 = 1'b0;
      check("busy_c1", (sel == 0) ? busy0 : busy8, 1);
      tick();
      check("valid_c2", (sel == 0) ? cv0 : cv8, 0);
      tick();
      check("latency", (sel == 0) ? cv0 : cv8, 1);
      check("busy_c3", (sel == 0) ? busy0 : busy8, 0);
   endtask

   initial begin
      rst0 = 1'b1; rst8 = 1'b1; pv0 = 1'b0; pv8 = 1'b0; pd0 = '0; pd8 = '0;
      tick();
      do_reset();

      // Basic PI response, positive then negative errors.
      send(0, 10);
      check("p_e10_a", word0, 2098);
      send(0, 10);
      check("p_e10_b", word0, 2108);
      tick();
      check("pulse_width", cv0, 0);

      do_reset();
      send(0, -10);
      check("n_e10", word0, 1998);
      send(0, -16);
      check("n_e16", word0, 1958);

      // Small accumulator saturates instead of wrapping.
      for (int i = 0; i < 9; i++) send(1, 15);
      check("acc8_word", word8, 2235);
      send(1, -16);

      // Overrun: second strobe while busy is dropped and sticky.
      do_reset();
      pv0 = 1'b1; pd0 = 5'd5;
      model_push(0, 5);
      tick();
      check("ovr_c1", ovr0, 0);
      pd0 = 5'd7;                       // dropped sample
      tick();
      pv0 = 1'b0;
      check("ovr_c2", ovr0, 1);
      tick();
      check("ovr_pulse", cv0, 1);
      tick();
      check("ovr_sticky", ovr0, 1);
      check("ovr_single", cv0, 0);

      // Reset during INTEG/SUM aborts the sample with no pulse.
      pv0 = 1'b1; pd0 = 5'd9;
      tick();
      pv0 = 1'b0;
      tick();
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      check("abort_word", word0, 2048);
      check("abort_valid", cv0, 0);
      check("abort_busy", busy0, 0);
      check("abort_lock", lock0, 0);
      check("abort_ovr", ovr0, 0);
      m_integ[0] = 0; m_cnt[0] = 0;
      for (int i = 0; i < 4; i++) tick();

      // Lock acquisition, loss, and -1 counting as in tolerance.
      do_reset();
      for (int i = 0; i < 7; i++) send(0, 0);
      check("lock_7", lock0, 0);
      send(0, 0);
      check("lock_8", lock0, 1);
      send(0, 3);
      check("lock_lost", lock0, 0);
      for (int i = 0; i < 8; i++) send(0, -1);
      check("lock_neg1", lock0, 1);
      send(0, -16);
      check("lock_minneg", lock0, 0);

      // Random errors across the full input range.
      do_reset();
      for (int i = 0; i < 24; i++) send(0, int'($urandom_range(0, 31)) - 16);

      // Long positive run drives the word to the top rail and holds it.
      do_reset();
      for (int i = 0; i < 200; i++) send(0, 15);
      check("rail_hi", word0, 4095);

      for (int i = 0; i < 3; i++) tick();
      check("pending0", exp_q0.size(), 0);
      check("pending8", exp_q8.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/loop_filter.md
LOOP_FILTER -- requirements
Module: loop_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5: width of the signed phase-error input.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 16: width of the signed integral accumulator.
REQ-003 The block SHALL have parameter OUT_WIDTH, default 12: width of the unsigned control word.
REQ-004 The block SHALL have parameter KP_SHIFT, default 2: proportional gain, applied as an arithmetic left shift.
REQ-005 The block SHALL have parameter KI_SHIFT, default 0: integral gain, applied as an arithmetic left shift.
REQ-006 The block SHALL have parameter CENTER, default 2048: nominal control word.
REQ-007 The block SHALL have parameters LOCK_TOL, default 1, and LOCK_COUNT, default 8: lock tolerance and the number of consecutive in-tolerance samples needed to declare lock.
REQ-008 fpga_clk_i  in  1  the single system clock; reset is synchronous and active-high.
REQ-009 reset_i  in  1  synchronous, active-high reset.
REQ-010 pd_clock_cycles_i  in  WIDTH  signed phase error, in fpga_clk cycles, from the phase detector.
REQ-011 pd_valid_i  in  1  one-cycle pulse marking a new pd_clock_cycles_i sample.
REQ-012 control_word_o  out  OUT_WIDTH  unsigned DCO frequency control word.
REQ-013 control_valid_o  out  1  one-cycle pulse marking an updated control_word_o.
REQ-014 busy_o  out  1  high while a sample is being processed.
REQ-015 lock_o  out  1  loop-locked indication.
REQ-016 overrun_o  out  1  sticky flag: a sample was dropped.

Function
REQ-017 The FSM SHALL have states IDLE, INTEG and SUM; busy_o SHALL be high exactly when the state is not IDLE.
REQ-018 In IDLE, when pd_valid_i=1, the block SHALL capture pd_clock_cycles_i (sign-extended) and go to INTEG.
REQ-019 In INTEG, the block SHALL set integ <= sat_ACC(integ + (e <<< KI_SHIFT)) and go to SUM.
REQ-020 In SUM, the block SHALL register control_word_o <= clamp(CENTER + (e <<< KP_SHIFT) + integ, 0, 2^OUT_WIDTH-1), pulse control_valid_o and go to IDLE.
REQ-021 Latency: pd_valid_i high in cycle 0 SHALL produce control_valid_o high in cycle 3, for exactly one cycle.
REQ-022 A new sample SHALL be accepted in cycle 3, so the sustained throughput is one sample per 3 cycles.
REQ-023 When pd_valid_i=1 in INTEG or SUM, the sample SHALL be dropped and overrun_o set; overrun_o SHALL be cleared only by reset.
REQ-024 Saturation in REQ-019 SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and never wrap.
REQ-025 The REQ-020 sum SHALL be computed at ACC_WIDTH+2 bits before the clamp.
REQ-026 Lock counter, updated in the SUM cycle:
- when |e| <= LOCK_TOL, the counter SHALL increment, saturating at LOCK_COUNT;
- otherwise the counter SHALL clear;
- lock_o SHALL equal (counter == LOCK_COUNT), registered, changing in the same cycle as control_valid_o.
REQ-027 The input e = -2^(WIDTH-1) SHALL be handled without overflow: its magnitude is taken at WIDTH+1 bits.

Reset
REQ-028 When reset_i=1, the following SHALL take effect at the next edge, regardless of state:
- state = IDLE, integ = 0, lock counter = 0;
- control_word_o = CENTER;
- control_valid_o = 0, busy_o = 0, lock_o = 0, overrun_o = 0.
REQ-029 Reset asserted mid-operation SHALL abort the sample, and no control_valid_o pulse SHALL follow.
REQ-030 pd_valid_i SHALL be ignored in any cycle where reset_i=1.

Structure
REQ-031 Shared package adpll_pkg SHALL hold the FSM state typedef (IDLE/INTEG/SUM) and the default parameter constants.
REQ-032 A single sub-module, signed_saturate (parameterised input and output widths, signed clamp), SHALL be used for both REQ-019 and the REQ-020 clamp.
REQ-033 All outputs SHALL be registered.

Verification (defaults unless stated)
REQ-034 Reset, then one sample e=10:
- control_valid_o SHALL pulse 3 cycles later with control_word_o=2098 (integ 10, prop 40);
- a second sample e=10 SHALL give 2108.
REQ-035 From reset, e=-10 (5'b10110) SHALL give 1998; then e=-16 SHALL give 1958 (integ -26, prop -64).
REQ-036 With ACC_WIDTH=8, nine samples of e=15 SHALL leave integ=127 (saturated, no wrap); the ninth word SHALL be 2235.
REQ-037 Overrun and reset abort:
- pd_valid_i in cycles 0 and 1 SHALL yield exactly one control_valid_o pulse, and overrun_o=1 from cycle 2 onward;
- reset_i in cycle 2 SHALL give no pulse, and all outputs SHALL equal their reset values.
REQ-038 Lock:
- eight samples of e=0 SHALL raise lock_o with the eighth control_valid_o;
- a following sample e=3 SHALL drop lock_o;
- e=-1 SHALL count as in tolerance.
REQ-039 Two hundred samples of e=15 SHALL drive control_word_o to 4095, held there (clamped, no wrap).
